event_sequencer: RTL and testbench
==================================

EVENT_SEQUENCER -- requirements
Module: event_sequencer

Interface
REQ-001 SHALL have parameter FALL_BASE, default 50_000_000, meaning fall-tick period in clk cycles at level 0.
REQ-002 SHALL have parameter REPEAT_DELAY, default 30_000_000, meaning cycles an arrow key is held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 8_000_000, meaning cycles between auto-repeat events.
REQ-004 SHALL have port clk, input, 1, the 100 MHz system clock, which is the only clock.
REQ-005 SHALL have port rst_n, input, 1, with reset asynchronous and active-low.
REQ-006 SHALL have port key_pulse, input, 5, one-cycle key-press pulses: [0] UP, [1] DOWN, [2] RIGHT, [3] LEFT, [4] SPACE.
REQ-007 SHALL have port key_hold, input, 5, key-held levels using the same bit order as key_pulse.
REQ-008 SHALL have port level, input, 2, the speed level 0..3.
REQ-009 SHALL have port enable, input, 1, which gates fall-tick generation when low.
REQ-010 SHALL have port event_received, input, 6, per-bit acknowledge from the consumer.
REQ-011 SHALL have port event_out, output, 6, pending events: [0] KEY_UP, [1] KEY_DOWN, [2] KEY_RIGHT, [3] KEY_LEFT, [4] FALL, [5] KEY_SPACE.

Function
REQ-012 SHALL hold each event_out bit sticky: set on its source, and cleared only by the matching event_received bit.
REQ-013 SHALL give set priority when a set and event_received occur on the same bit in the same cycle, so the bit stays 1.
REQ-014 SHALL map key_pulse[3:0] to event_out[3:0] and key_pulse[4] to event_out[5], with the bit set in the cycle after the pulse (1-cycle latency).
REQ-015 SHALL use a 32-bit fall counter that increments each cycle while enable=1 and holds its value while enable=0.
REQ-016 SHALL compute the fall period as P = FALL_BASE >> level.
REQ-017 SHALL, when the fall counter reaches P-1, reset it to 0 and set event_out[4] in the next cycle.
REQ-018 SHALL restart the fall counter at 0 on any change of level, with no FALL generated in that cycle.
REQ-019 SHALL restart the fall counter at 0 when key_pulse[1] (DOWN) is seen, so a manual drop is not followed by an immediate fall.
REQ-020 SHALL implement auto-repeat as an FSM with states IDLE, DELAY and REPEAT, driven by one 32-bit repeat counter; repeat covers DOWN, RIGHT and LEFT only.
REQ-021 SHALL, in IDLE on any key_pulse[3:1], go to DELAY with the counter at 0.
REQ-022 SHALL, in DELAY, count while any of key_hold[3:1]=1, and at REPEAT_DELAY-1 go to REPEAT with the counter at 0 and set event_out bits for all held arrows.
REQ-023 SHALL, in REPEAT, set event_out bits for all held arrows every REPEAT_RATE cycles.
REQ-024 SHALL go to IDLE from DELAY or REPEAT when key_hold[3:1]=0.
REQ-025 SHALL, on a new key_pulse[3:1] in DELAY or REPEAT, go to DELAY with the counter at 0.
REQ-026 SHALL never auto-repeat UP or SPACE.
REQ-027 SHALL make an auto-repeat set of DOWN also restart the fall counter.
REQ-028 SHALL let simultaneous key pulses set all corresponding bits in the same cycle, with no arbitration here.
REQ-029 SHALL keep the fall counter and repeat counter from wrapping: both compare with >= against their terminal value.

Reset
REQ-030 SHALL, while rst_n=0, immediately clear event_out to 0, clear both counters to 0, and put the FSM in IDLE, regardless of clk.
REQ-031 SHALL abandon a reset asserted mid-operation with no residual events, and SHALL count the first fall period from 0 after rst_n rises.

Verification
REQ-032 SHALL check key latching (FALL_BASE=16, enable=0): key_pulse=5'b00100 for 1 cycle gives event_out=6'b000100 next cycle and held for 10 cycles; event_received=6'b000100 gives 0 the next cycle.
REQ-033 SHALL check the fall tick (FALL_BASE=16, level=0, enable=1): event_out[4] rises at cycle 16 after reset release; acknowledge, then it rises again 16 cycles later; with level=2 the period is 4.
REQ-034 SHALL check set priority: key_pulse[0] and event_received[0] in the same cycle give event_out[0]=1.
REQ-035 SHALL check auto-repeat (REPEAT_DELAY=8, REPEAT_RATE=4): LEFT pulse with key_hold[3]=1, acknowledging every cycle, gives event_out[3] sets at cycles 1, 9, 13, 17; releasing the hold gives no further sets.
REQ-036 SHALL check DOWN-restarts-fall (FALL_BASE=16): key_pulse[1] at count 10 means no FALL until 16 cycles after that pulse.
REQ-037 SHALL check mid-operation reset: rst_n=0 asynchronously during REPEAT with event_out=6'b011000 gives event_out=0 before the next clk edge and the FSM in IDLE.

Source files
------------

// File: rtl/event_sequencer.sv
// Event sequencer: turns key presses, periodic fall ticks and arrow auto-repeat
// into sticky event flags that the consumer acknowledges bit by bit.
module event_sequencer #(
    parameter int unsigned FALL_BASE    = 50_000_000,
    parameter int unsigned REPEAT_DELAY = 30_000_000,
    parameter int unsigned REPEAT_RATE  = 8_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_pulse,
    input  logic [4:0] key_hold,
    input  logic [1:0] level,
    input  logic       enable,
    input  logic [5:0] event_received,
    output logic [5:0] event_out
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    localparam logic [31:0] FALL_BASE_W = 32'(FALL_BASE);
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LAST   = 32'(REPEAT_RATE - 1);

    rep_state_t  state, state_next;
    logic [31:0] rep_cnt, rep_cnt_next;
    logic [31:0] fall_cnt, fall_cnt_next;
    logic [31:0] fall_period;
    logic [1:0]  level_q;
    logic        fall_fire, fall_restart;
    logic [2:0]  arrow_pulse, arrow_hold, rep_fire;
    logic [5:0]  set_vec;
    logic        unused_hold;

    assign arrow_pulse = key_pulse[3:1];
    assign arrow_hold  = key_hold[3:1];
    assign unused_hold = ^{key_hold[4], key_hold[0]};

    // Auto-repeat: a fresh arrow press always re-arms the initial delay.
    always_comb begin
        state_next   = state;
        rep_cnt_next = rep_cnt;
        rep_fire     = 3'b000;
        case (state)
            IDLE: begin
                if (|arrow_pulse) begin
                    state_next   = DELAY;
                    rep_cnt_next = '0;
                end
            end
            DELAY, REPEAT: begin
                if (|arrow_pulse) begin
                    state_next   = DELAY;
                    rep_cnt_next = '0;
                end else if (arrow_hold == 3'b000) begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end else if (rep_cnt >= ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    state_next   = REPEAT;
                    rep_cnt_next = '0;
                    rep_fire     = arrow_hold;
                end else begin
                    rep_cnt_next = rep_cnt + 32'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                rep_cnt_next = '0;
            end
        endcase
    end

    // A manual or repeated drop restarts the fall period so no fall follows it at once.
    always_comb begin
        fall_period   = FALL_BASE_W >> level;
        fall_restart  = (level != level_q) | key_pulse[1] | rep_fire[0];
        fall_fire     = 1'b0;
        fall_cnt_next = fall_cnt;
        if (fall_restart) begin
            fall_cnt_next = '0;
        end else if (enable) begin
            if (fall_cnt >= fall_period - 32'd1) begin
                fall_cnt_next = '0;
                fall_fire     = 1'b1;
            end else begin
                fall_cnt_next = fall_cnt + 32'd1;
            end
        end
    end

    assign set_vec = {key_pulse[4], fall_fire, arrow_pulse | rep_fire, key_pulse[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            fall_cnt  <= '0;
            level_q   <= 2'd0;
            event_out <= '0;
        end else begin
            state     <= state_next;
            rep_cnt   <= rep_cnt_next;
            fall_cnt  <= fall_cnt_next;
            level_q   <= level;
            event_out <= (event_out & ~event_received) | set_vec;
        end
    end
endmodule

// File: tb/tb_event_sequencer.sv
// Bench for event_sequencer: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_event_sequencer;
    localparam int FALL_BASE    = 16;
    localparam int REPEAT_DELAY = 8;
    localparam int REPEAT_RATE  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] key_pulse = '0;
    logic [4:0] key_hold = '0;
    logic [1:0] level = '0;
    logic       enable = 1'b0;
    logic [5:0] event_received = '0;
    logic [5:0] event_out;

    int checks = 0;
    int failures = 0;

    logic [5:0] exp_events = '0;
    int         fall_run = 0;
    logic [1:0] prev_level = '0;
    bit         rep_active = 0;
    int         rep_age = 0;

    event_sequencer #(
        .FALL_BASE   (FALL_BASE),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_pulse     (key_pulse),
        .key_hold      (key_hold),
        .level         (level),
        .enable        (enable),
        .event_received(event_received),
        .event_out     (event_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] pulse, input logic [4:0] hold,
                                 input logic [1:0] lvl, input logic en, input logic [5:0] rcv);
        key_pulse      = pulse;
        key_hold       = hold;
        level          = lvl;
        enable         = en;
        event_received = rcv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic en);
        rst_n = 1'b0;
        applyStimulus(5'b0, 5'b0, 2'd0, en, 6'b0);
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Acknowledge FALL, then count edges until it is raised again.
    task automatic measureFall(input logic [1:0] lvl, output int n);
        level = lvl;
        event_received = 6'b010000;
        tick;
        event_received = 6'b0;
        n = 1;
        while (!event_out[4] && n < 100) begin
            tick;
            n++;
        end
    endtask

    // Model: counts enabled cycles since the last restart, and tracks the age of
    // the current arrow press to decide when auto-repeat events land.
    task automatic modelStep;
        automatic logic [2:0] rep = 3'b000;
        automatic bit fell = 0;
        automatic int period = FALL_BASE >> level;
        automatic bit restart;
        if (|key_pulse[3:1]) begin
            rep_active = 1;
            rep_age = 0;
        end else if (rep_active && key_hold[3:1] == 3'b000) begin
            rep_active = 0;
        end else if (rep_active) begin
            rep_age++;
            if (rep_age == REPEAT_DELAY ||
                (rep_age > REPEAT_DELAY && (rep_age - REPEAT_DELAY) % REPEAT_RATE == 0))
                rep = key_hold[3:1];
        end
        restart = (level != prev_level) || key_pulse[1] || rep[0];
        prev_level = level;
        if (restart) begin
            fall_run = 0;
        end else if (enable) begin
            fall_run++;
            if (fall_run >= period) begin
                fell = 1;
                fall_run = 0;
            end
        end
        exp_events = (exp_events & ~event_received) |
                     {key_pulse[4], fell, key_pulse[3:1] | rep, key_pulse[0]};
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_events = '0;
                fall_run   = 0;
                prev_level = '0;
                rep_active = 0;
                rep_age    = 0;
            end else begin
                modelStep();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) checkOutput("model", int'(event_out), int'(exp_events));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int first_rise;
        logic [31:0] mask;

        #1;
        doReset(1'b0);
        checkOutput("reset_state", int'(event_out), 0);

        // Key latching with fall disabled
        applyStimulus(5'b00100, 5'b0, 2'd0, 1'b0, 6'b0);
        tick;
        applyStimulus(5'b00000, 5'b0, 2'd0, 1'b0, 6'b0);
        checkOutput("key_latch", int'(event_out), 6'b000100);
        for (int i = 0; i < 10; i++) begin
            tick;
            checkOutput("key_sticky", int'(event_out), 6'b000100);
        end
        event_received = 6'b000100;
        tick;
        event_received = 6'b0;
        checkOutput("key_ack", int'(event_out), 0);

        // Set wins over a same-cycle acknowledge
        applyStimulus(5'b00001, 5'b0, 2'd0, 1'b0, 6'b0);
        tick;
        applyStimulus(5'b00001, 5'b0, 2'd0, 1'b0, 6'b000001);
        tick;
        applyStimulus(5'b00000, 5'b0, 2'd0, 1'b0, 6'b0);
        checkOutput("set_priority", int'(event_out), 6'b000001);
        event_received = 6'b000001;
        tick;
        event_received = 6'b0;
        checkOutput("up_ack", int'(event_out), 0);

        // Simultaneous pulses all land together
        applyStimulus(5'b11111, 5'b0, 2'd0, 1'b0, 6'b0);
        tick;
        applyStimulus(5'b00000, 5'b0, 2'd0, 1'b0, 6'b0);
        checkOutput("all_keys", int'(event_out), 6'b101111);
        event_received = 6'b111111;
        tick;
        event_received = 6'b0;
        checkOutput("all_ack", int'(event_out), 0);

        // Fall tick at level 0, then level 2
        doReset(1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick;
            checkOutput("fall_first", int'(event_out[4]), (i == 16) ? 1 : 0);
        end
        measureFall(2'd0, n);
        checkOutput("fall_period_l0", n, 16);
        measureFall(2'd2, n);
        checkOutput("fall_level_change", n, 5);
        measureFall(2'd2, n);
        checkOutput("fall_period_l2", n, 4);

        // DOWN at count 10 restarts the fall period
        doReset(1'b1);
        for (int i = 0; i < 10; i++) tick;
        applyStimulus(5'b00010, 5'b0, 2'd0, 1'b1, 6'b0);
        tick;
        applyStimulus(5'b00000, 5'b0, 2'd0, 1'b1, 6'b0);
        n = 0;
        while (!event_out[4] && n < 100) begin
            tick;
            n++;
        end
        checkOutput("down_restarts_fall", n, 16);

        // LEFT auto-repeat with continuous acknowledge
        doReset(1'b0);
        mask = '0;
        applyStimulus(5'b01000, 5'b01000, 2'd0, 1'b0, 6'b001000);
        tick;
        mask[1] = event_out[3];
        applyStimulus(5'b00000, 5'b01000, 2'd0, 1'b0, 6'b001000);
        for (int e = 2; e <= 18; e++) begin
            tick;
            mask[e] = event_out[3];
        end
        key_hold = 5'b0;
        for (int e = 19; e <= 28; e++) begin
            tick;
            mask[e] = event_out[3];
        end
        checkOutput("repeat_pattern", int'(mask), 32'h0002_2202);

        // Asynchronous reset while repeating with FALL and LEFT pending
        doReset(1'b1);
        applyStimulus(5'b01000, 5'b01000, 2'd0, 1'b1, 6'b0);
        tick;
        key_pulse = 5'b0;
        for (int i = 2; i <= 16; i++) tick;
        checkOutput("pre_reset_events", int'(event_out), 6'b011000);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear", int'(event_out), 0);
        tick;
        rst_n = 1'b1;
        mask = '0;
        first_rise = 0;
        for (int i = 1; i <= 16; i++) begin
            tick;
            mask[i] = event_out[3];
            if (event_out[4] && first_rise == 0) first_rise = i;
        end
        checkOutput("idle_after_reset", int'(mask), 0);
        checkOutput("fall_after_reset", first_rise, 16);

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
